// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM driving datapath enables/selects.
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl #(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 3,
   parameter int ST_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    opcode,
   input  logic [OP_W-1:0]    funct,
   input  logic               zero,
   output logic               pc_we,
   output logic [1:0]         pc_src,
   output logic               iord,
   output logic               ir_we,
   output logic               mem_we,
   output logic               reg_we,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               imm_zext,
   output logic [ALUOP_W-1:0] alu_op,
`ifdef MULTICYCLE_CTRL_PERF_EN
   output logic [31:0]        cycle_cnt,
   output logic [31:0]        instr_cnt,
`endif
   output logic [ST_W-1:0]    state,
   output logic               illegal
);
   typedef enum logic [ST_W-1:0] {
      S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3, S_MEM_WB = 4,
      S_MEM_WRITE = 5, S_R_EXEC = 6, S_R_WB = 7, S_BRANCH = 8, S_JUMP = 9,
      S_I_EXEC = 10, S_I_WB = 11, S_JR = 12, S_JAL = 13, S_ILLEGAL = 15
   } state_t;
   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
      OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [OP_W-1:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;
   localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_SLT = 3'd3;
   state_t st_q, nxt;
   always_ff @(posedge clk)
      st_q <= reset ? S_FETCH : nxt;
   always_comb begin
      nxt        = st_q;
      pc_we      = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      ir_we      = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      imm_zext   = 1'b0;
      alu_op     = ALU_ADD;
      case (st_q)
         S_FETCH: begin
            ir_we     = 1'b1;
            alu_src_b = 2'b01;
            pc_we     = 1'b1;
            nxt       = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW:   nxt = S_MEM_ADDR;
               OP_RTYPE:       nxt = funct == FN_JR ? S_JR :
                                     (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT) ? S_R_EXEC : S_ILLEGAL;
               OP_BEQ, OP_BNE: nxt = S_BRANCH;
               OP_J:           nxt = S_JUMP;
               OP_JAL:         nxt = S_JAL;
               OP_ADDI, OP_XORI: nxt = S_I_EXEC;
               default:        nxt = S_ILLEGAL;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt       = opcode == OP_LW ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            iord = 1'b1;
            nxt  = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_we     = 1'b1;
            mem_to_reg = 2'b01;
            nxt        = S_FETCH;
         end
         S_MEM_WRITE: begin
            iord   = 1'b1;
            mem_we = 1'b1;
            nxt    = S_FETCH;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = funct == FN_SUB ? ALU_SUB : funct == FN_SLT ? ALU_SLT : ALU_ADD;
            nxt       = S_R_WB;
         end
         S_R_WB: begin
            reg_we  = 1'b1;
            reg_dst = 2'b01;
            nxt     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'b01;
            pc_we     = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
            nxt       = S_FETCH;
         end
         S_JUMP: begin
            pc_src = 2'b10;
            pc_we  = 1'b1;
            nxt    = S_FETCH;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            imm_zext  = opcode == OP_XORI;
            alu_op    = opcode == OP_XORI ? ALU_XOR : ALU_ADD;
            nxt       = S_I_WB;
         end
         S_I_WB: begin
            reg_we = 1'b1;
            nxt    = S_FETCH;
         end
         S_JR: begin
            pc_src = 2'b11;
            pc_we  = 1'b1;
            nxt    = S_FETCH;
         end
         S_JAL: begin
            pc_src     = 2'b10;
            pc_we      = 1'b1;
            reg_we     = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            nxt        = S_FETCH;
         end
         default: nxt = S_ILLEGAL;
      endcase
      // Reset forces every output quiet, whatever state the register holds.
      if (reset) begin
         {pc_we, pc_src, iord, ir_we, mem_we, reg_we, reg_dst, mem_to_reg} = '0;
         {alu_src_a, alu_src_b, imm_zext, alu_op} = '0;
      end
   end
   assign state   = reset ? '0 : st_q;
   assign illegal = !reset && st_q == S_ILLEGAL;
`ifdef MULTICYCLE_CTRL_PERF_EN
   always_ff @(posedge clk)
      if (reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else if (st_q != S_ILLEGAL) begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (nxt == S_FETCH && st_q != S_FETCH) instr_cnt <= instr_cnt + 32'd1;
      end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven scoreboard bench for multicycle_ctrl.
module tb_multicycle_ctrl;
   logic clk = 1'b0, reset, zero;
   logic [5:0] opcode, funct;
   logic pc_we, iord, ir_we, mem_we, reg_we, alu_src_a, imm_zext, illegal;
   logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
   logic [2:0] alu_op;
   logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif
   typedef struct packed {
      logic pc_we; logic [1:0] pc_src; logic iord, ir_we, mem_we, reg_we;
      logic [1:0] reg_dst, mem_to_reg; logic alu_src_a; logic [1:0] alu_src_b;
      logic imm_zext; logic [2:0] alu_op; logic [3:0] state; logic illegal;
   } out_t;
   typedef struct {
      string nm; logic [5:0] op, fn; logic z; int n; logic [4:0][3:0] s;
   } vec_t;
   out_t act, sb[$];
   vec_t tbl[14], bad_op, bad_fn, lw;
   int checks = 0, failures = 0;
   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_we(pc_we), .pc_src(pc_src), .iord(iord), .ir_we(ir_we), .mem_we(mem_we),
      .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op),
`ifdef MULTICYCLE_CTRL_PERF_EN
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
      .state(state), .illegal(illegal)
   );
   always #5 clk = ~clk;
   assign act = '{pc_we, pc_src, iord, ir_we, mem_we, reg_we, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, imm_zext, alu_op, state, illegal};
   function automatic vec_t mk(input string nm, input logic [5:0] op, fn, input logic z, input int n,
                               input logic [3:0] s0, s1, s2, s3, s4);
      vec_t v;
      v.nm = nm; v.op = op; v.fn = fn; v.z = z; v.n = n; v.s = {s4, s3, s2, s1, s0};
      return v;
   endfunction
   // Expected outputs per state, written straight from the state table.
   function automatic out_t exp_out(input logic [3:0] s, input logic [5:0] op, fn, input logic z);
      out_t o = '0;
      o.state = s;
      case (s)
         4'd0:  begin o.pc_we = 1; o.ir_we = 1; o.alu_src_b = 2'b01; end
         4'd1:  o.alu_src_b = 2'b11;
         4'd2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         4'd3:  o.iord = 1;
         4'd4:  begin o.reg_we = 1; o.mem_to_reg = 2'b01; end
         4'd5:  begin o.iord = 1; o.mem_we = 1; end
         4'd6:  begin o.alu_src_a = 1; o.alu_op = fn == 6'h22 ? 3'd1 : fn == 6'h2A ? 3'd3 : 3'd0; end
         4'd7:  begin o.reg_we = 1; o.reg_dst = 2'b01; end
         4'd8:  begin o.alu_src_a = 1; o.alu_op = 3'd1; o.pc_src = 2'b01; o.pc_we = op == 6'h04 ? z : !z; end
         4'd9:  begin o.pc_src = 2'b10; o.pc_we = 1; end
         4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.imm_zext = op == 6'h0E; o.alu_op = op == 6'h0E ? 3'd2 : 3'd0; end
         4'd11: o.reg_we = 1;
         4'd12: begin o.pc_src = 2'b11; o.pc_we = 1; end
         4'd13: begin o.pc_src = 2'b10; o.pc_we = 1; o.reg_we = 1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; end
         4'd15: o.illegal = 1;
         default: ;
      endcase
      return o;
   endfunction
   task automatic chk(input string nm, input out_t e);
      out_t x;
      sb.push_back(e);
      x = sb.pop_front();
      checks++;
      if (act !== x) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h (state got=%0d exp=%0d)", nm, $time, act, x, act.state, x.state);
      end
   endtask
   task automatic run_n(input vec_t v, input int k);
      for (int i = 0; i < k; i++) begin
         opcode = v.op; funct = v.fn; zero = v.z;
         #1 chk(v.nm, exp_out(v.s[i], v.op, v.fn, v.z));
         @(posedge clk); #1;
      end
   endtask
   task automatic do_reset();
      reset = 1'b1;
      #1 chk("reset_quiet", '0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask
   initial begin
      tbl[0]  = mk("lw",    6'h23, 6'h00, 0, 5, 0, 1, 2, 3, 4);
      tbl[1]  = mk("sw",    6'h2B, 6'h00, 0, 4, 0, 1, 2, 5, 0);
      tbl[2]  = mk("add",   6'h00, 6'h20, 0, 4, 0, 1, 6, 7, 0);
      tbl[3]  = mk("sub",   6'h00, 6'h22, 1, 4, 0, 1, 6, 7, 0);
      tbl[4]  = mk("slt",   6'h00, 6'h2A, 0, 4, 0, 1, 6, 7, 0);
      tbl[5]  = mk("beq_t", 6'h04, 6'h00, 1, 3, 0, 1, 8, 0, 0);
      tbl[6]  = mk("beq_f", 6'h04, 6'h00, 0, 3, 0, 1, 8, 0, 0);
      tbl[7]  = mk("bne_t", 6'h05, 6'h00, 0, 3, 0, 1, 8, 0, 0);
      tbl[8]  = mk("bne_f", 6'h05, 6'h00, 1, 3, 0, 1, 8, 0, 0);
      tbl[9]  = mk("j",     6'h02, 6'h00, 0, 3, 0, 1, 9, 0, 0);
      tbl[10] = mk("jal",   6'h03, 6'h00, 0, 3, 0, 1, 13, 0, 0);
      tbl[11] = mk("jr",    6'h00, 6'h08, 0, 3, 0, 1, 12, 0, 0);
      tbl[12] = mk("addi",  6'h08, 6'h00, 0, 4, 0, 1, 10, 11, 0);
      tbl[13] = mk("xori",  6'h0E, 6'h00, 1, 4, 0, 1, 10, 11, 0);
      bad_op  = mk("ill_op", 6'h3F, 6'h00, 0, 3, 0, 1, 15, 0, 0);
      bad_fn  = mk("ill_fn", 6'h00, 6'h01, 0, 3, 0, 1, 15, 0, 0);
      lw = tbl[0];
      reset = 1'b1; opcode = 6'h23; funct = '0; zero = 1'b0;
      repeat (2) begin
         @(posedge clk); #1 chk("reset_hold", '0);
      end
      reset = 1'b0;
      foreach (tbl[i]) run_n(tbl[i], tbl[i].n);
      repeat (20) begin
         int k = $urandom_range(0, 13);
         run_n(tbl[k], tbl[k].n);
      end
      run_n(lw, 3);
      do_reset();
      run_n(lw, lw.n);
      run_n(bad_op, 3);
      repeat (9) begin
         #1 chk("ill_hold", exp_out(4'd15, 6'h3F, 6'h00, 0));
         @(posedge clk); #1;
      end
      do_reset();
      run_n(tbl[10], tbl[10].n);
      run_n(bad_fn, 3);
      do_reset();
`ifdef MULTICYCLE_CTRL_PERF_EN
      checks++;
      if (cycle_cnt !== 0 || instr_cnt !== 0) begin
         failures++;
         $display("FAIL perf_clear got=%0d/%0d exp=0/0", cycle_cnt, instr_cnt);
      end
      repeat (3) run_n(tbl[3], 4);
      checks++;
      if (cycle_cnt !== 32'd12 || instr_cnt !== 32'd3) begin
         failures++;
         $display("FAIL perf_count got=%0d/%0d exp=12/3", cycle_cnt, instr_cnt);
      end
      run_n(bad_op, 3);
      repeat (5) @(posedge clk);
      #1 checks++;
      if (cycle_cnt !== 32'd14 || instr_cnt !== 32'd3) begin
         failures++;
         $display("FAIL perf_freeze got=%0d/%0d exp=14/3", cycle_cnt, instr_cnt);
      end
      do_reset();
`endif
      run_n(tbl[2], tbl[2].n);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the shared MIPS datapath (instruction/data memory, regfile, ALU, PC) over several cycles per instruction, replacing the single-cycle operand LUT.
- One memory port and one ALU are reused across states, selected by the mux-select outputs.
- Sits beside the instruction decoder: consumes opcode/funct from the instruction register and the ALU zero flag; drives every datapath enable and select.

Parameters:
- OP_W, 6, opcode/funct field width
- ALUOP_W, 3, ALU command width
- ST_W, 4, state register width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instruction bits [31:26], from IR
- funct  input  6  instruction bits [5:0], from IR
- zero  input  1  ALU zero flag, same cycle
- pc_we  output  1  PC register write enable
- pc_src  output  2  00 ALU result, 01 ALUOut reg, 10 {pc[31:28],jaddr,2'b00}, 11 regA
- iord  output  1  memory address select: 0 PC, 1 ALUOut
- ir_we  output  1  instruction register write enable
- mem_we  output  1  data memory write enable
- reg_we  output  1  regfile write enable
- reg_dst  output  2  00 rt, 01 rd, 10 r31
- mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a  output  1  0 PC, 1 regA
- alu_src_b  output  2  00 regB, 01 const 4, 10 ext imm, 11 sign-ext imm<<2
- imm_zext  output  1  1 = zero-extend imm (XORI), 0 = sign-extend
- alu_op  output  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
- state  output  4  current state, for debug
- illegal  output  1  sticky: unsupported opcode/funct decoded

Behaviour:
- Outputs are decoded from the state register, except pc_we in BRANCH, which also depends on zero. Unlisted outputs are 0 in each state.
- Reset: while reset=1 all outputs are 0 and illegal=0. On the next edge state=FETCH(0).
- FETCH(0):
  - Outputs: iord=0, ir_we=1, alu_src_a=0, alu_src_b=01, ADD, pc_src=00, pc_we=1.
  - Next: DECODE.
- DECODE(1):
  - Outputs: alu_src_a=0, alu_src_b=11, ADD (precomputes branch target into ALUOut).
  - Next, by opcode:
    - 0x23/0x2B -> MEM_ADDR
    - 0x00 with funct 0x08 -> JR
    - 0x00 with funct 0x20/0x22/0x2A -> R_EXEC
    - 0x04/0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - 0x08/0x0E -> I_EXEC
    - anything else -> ILLEGAL
- MEM_ADDR(2):
  - Outputs: alu_src_a=1, alu_src_b=10, ADD.
  - Next: LW -> MEM_READ; SW -> MEM_WRITE.
- MEM_READ(3): iord=1 -> MEM_WB.
- MEM_WB(4): reg_we=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WRITE(5): iord=1, mem_we=1 -> FETCH.
- R_EXEC(6):
  - Outputs: alu_src_a=1, alu_src_b=00.
  - alu_op by funct: 0x20 ADD, 0x22 SUB, 0x2A SLT.
  - Next: R_WB.
- R_WB(7): reg_we=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- BRANCH(8):
  - Outputs: alu_src_a=1, alu_src_b=00, SUB, pc_src=01.
  - pc_we = (BEQ & zero) | (BNE & ~zero).
  - Next: FETCH.
- JUMP(9): pc_src=10, pc_we=1 -> FETCH.
- I_EXEC(10):
  - Outputs: alu_src_a=1, alu_src_b=10.
  - ADDI: ADD, imm_zext=0. XORI: XOR, imm_zext=1.
  - Next: I_WB.
- I_WB(11): reg_we=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- JR(12): pc_src=11, pc_we=1 -> FETCH.
- JAL(13):
  - Outputs: pc_src=10, pc_we=1, reg_we=1, reg_dst=10, mem_to_reg=10.
  - Writes the already-incremented PC (PC+4) to r31 on the same edge the PC takes the jump target.
  - Next: FETCH.
- ILLEGAL(15): all enables 0, illegal=1. Stays here until reset.
- Unused encodings 14 and 15-alias go to ILLEGAL.
- Cycles per instruction: LW 5; SW, R-type, ADDI, XORI 4; BEQ, BNE, J, JAL, JR 3.
- opcode and funct are sampled only in DECODE/EXEC states. IR is stable from the edge after FETCH, because ir_we=1 only in FETCH.
- Reset asserted in any state, including mid-LW: the next state is FETCH and no write enable is asserted during the reset cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined, adds outputs cycle_cnt[31:0] and instr_cnt[31:0]:
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on each transition into FETCH from a non-FETCH state.
  - Both clear on reset, wrap at 2^32, and freeze in ILLEGAL.
- When undefined, neither port nor counter exists.

Test Plan:
- Reset held 2 cycles then released, opcode=0x23 -> state 0,1,2,3,4,0; reg_we=1 only in state 4 with mem_to_reg=01; pc_we=1 only in state 0.
- opcode=0x2B -> states 0,1,2,5,0; mem_we=1 only in state 5 with iord=1; reg_we never 1.
- opcode=0x00, funct=0x22 -> R_EXEC alu_op=001; R_WB reg_dst=01; 4 cycles total.
- opcode=0x04 with zero=1 -> pc_we=1, pc_src=01 in BRANCH; zero=0 -> pc_we=0. opcode=0x05 gives the inverse.
- opcode=0x03 -> JAL state: pc_we=1, reg_we=1, reg_dst=10, mem_to_reg=10, pc_src=10. opcode=0x00/funct=0x08 -> JR pc_src=11.
- opcode=0x3F -> ILLEGAL; illegal=1 held 10 cycles with all enables 0. Reset then returns to FETCH with illegal=0. With MULTICYCLE_CTRL_PERF_EN: 3 R-type instructions after reset give instr_cnt=3, cycle_cnt=12.
